chunk_subtractor: RTL and testbench
===================================

Name: chunk_subtractor

Overview:
- Multi-cycle borrow-ripple subtractor; the inverse operation of the combinational ripple-carry adder in the SIMD datapath.
- Computes diff = a - b - bin over BITS-wide operands, CHUNK bits per clock, using a start/done handshake.
- Used by lane arithmetic and round-counter bookkeeping where a full-width combinational borrow chain would limit timing.

Parameters:
- BITS, 64, operand/result width; must be a multiple of CHUNK.
- CHUNK, 8, bits processed per cycle; N = BITS/CHUNK cycles per operation.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only while idle.
- a  input  BITS  minuend; captured on accept.
- b  input  BITS  subtrahend; captured on accept.
- bin  input  1  borrow-in; captured on accept.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when diff/bout are valid.
- diff  output  BITS  result a - b - bin mod 2^BITS.
- bout  output  1  borrow-out; 1 iff a < b + bin (unsigned).

Behaviour:
- Reset: rst_n low asynchronously forces state IDLE and clears busy, done, diff, bout, chunk index and working registers to 0.
- States:
  - IDLE -> BUSY when start=1 at a rising edge (accept edge). a, b and bin are latched, index=0 and borrow=bin.
  - BUSY: each edge computes chunk[index] = a_chunk - b_chunk - borrow (CHUNK+1-bit arithmetic). The low CHUNK bits go to the working diff; the MSB becomes the next borrow; index increments.
  - BUSY -> IDLE on the edge that processes chunk N-1. On that edge diff <= full working result, bout <= final borrow, done <= 1, busy <= 0.
- Latency: accept at edge k; busy=1 from k through k+N-1; done=1 for exactly the cycle following edge k+N.
- diff/bout change only on the completion edge. They hold their last value otherwise; no partial results are visible.
- start while busy is ignored and the latched operands are unaffected.
- start high in the cycle where done=1 is accepted (state is IDLE), so back-to-back throughput is one result per N cycles.
- Index counter wraps to 0 at completion; no other wrap paths exist.
- Reset asserted mid-operation aborts: the partial result is discarded and no done pulse is issued.
- CHUNK = BITS is legal: N=1, single-cycle compute, done one cycle after accept.

Optional Feature:
- Macro SUB_OVERFLOW_EN.
- Defined: adds output port ovf (output, 1). ovf is the two's-complement signed overflow of a - b - bin, computed from the sign bits a[BITS-1], b[BITS-1] and diff[BITS-1]. It updates on the completion edge together with diff and resets to 0.
- Undefined: the ovf port and its logic are absent; all other behaviour is identical.

Test Plan:
- Basic: BITS=64, CHUNK=8; a=0x10, b=0x01, bin=0, start pulse -> busy for 8 cycles; done on 9th cycle after accept; diff=0xF, bout=0.
- Full borrow ripple: a=0, b=1, bin=0 -> diff=0xFFFF_FFFF_FFFF_FFFF, bout=1.
- Borrow-in: a=b=0x0123_4567_89AB_CDEF, bin=1 -> diff=0xFFFF_FFFF_FFFF_FFFF, bout=1. Same operands with bin=0 -> diff=0, bout=0.
- Handshake: start held high throughout with operands changed mid-op -> first result uses the originally latched values. A new op is accepted in the done cycle; its done follows exactly 8 cycles later.
- Reset mid-op: drop rst_n 3 cycles after accept -> busy, done, diff and bout immediately 0; no done pulse. The next op a=5, b=3 -> diff=2, bout=0.
- SUB_OVERFLOW_EN defined: a=0x8000_0000_0000_0000, b=1, bin=0 -> diff=0x7FFF_FFFF_FFFF_FFFF, bout=0, ovf=1. Then a=3, b=5 -> ovf=0, bout=1.

Source files
------------

// File: rtl/chunk_subtractor.sv
// chunk_subtractor: multi-cycle borrow-ripple subtractor.
// Computes diff = a - b - bin over BITS-wide operands, CHUNK bits per clock,
// with a start/done handshake. One operation takes N = BITS/CHUNK busy cycles.
// Optional feature macro: SUB_OVERFLOW_EN adds the signed-overflow output ovf.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for start; diff/bout hold the last completed result
// S_BUSY | one chunk subtracted per edge, chunk index 0 .. N-1
module chunk_subtractor #(
  parameter int BITS  = 64,
  parameter int CHUNK = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            bin,
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] diff,
  output logic            bout
`ifdef SUB_OVERFLOW_EN
  ,
  output logic            ovf
`endif
);

  localparam int N  = BITS / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t          state, state_nxt;
  logic            accept, last;
  logic [IW-1:0]   idx;
  logic [BITS-1:0] a_r, b_r, work, work_nxt;
  logic            borrow;
  logic [CHUNK:0]  sub;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode: start is only looked at while idle.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (idx == LAST) begin
          last      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // One chunk of CHUNK+1-bit subtraction; the MSB is the borrow into the next chunk.
  always_comb begin
    sub      = {1'b0, a_r[idx*CHUNK +: CHUNK]} - {1'b0, b_r[idx*CHUNK +: CHUNK]}
             - {{CHUNK{1'b0}}, borrow};
    work_nxt = work;
    work_nxt[idx*CHUNK +: CHUNK] = sub[CHUNK-1:0];
  end

  // Operand capture, chunk walk, and result publication on the final chunk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= '0;
      b_r    <= '0;
      borrow <= 1'b0;
      idx    <= '0;
      work   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      ovf    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_r    <= a;
        b_r    <= b;
        borrow <= bin;
        idx    <= '0;
        work   <= '0;
        busy   <= 1'b1;
      end else if (state == S_BUSY) begin
        work   <= work_nxt;
        borrow <= sub[CHUNK];
        if (last) begin
          idx  <= '0;
          diff <= work_nxt;
          bout <= sub[CHUNK];
          done <= 1'b1;
          busy <= 1'b0;
`ifdef SUB_OVERFLOW_EN
          // Overflow when operand signs differ and the result sign leaves a's sign.
          ovf  <= (a_r[BITS-1] ^ b_r[BITS-1]) & (work_nxt[BITS-1] ^ a_r[BITS-1]);
`endif
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_chunk_subtractor.sv
// Self-checking bench for chunk_subtractor (BITS=64, CHUNK=8).
// A transaction-level reference model is compared against the DUT every cycle;
// directed operations additionally pin results and latencies to literal values.
module tb_chunk_subtractor;

  localparam int BITS  = 64;
  localparam int CHUNK = 8;
  localparam int N     = BITS / CHUNK;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [BITS-1:0] a = '0;
  logic [BITS-1:0] b = '0;
  logic            bin = 1'b0;
  logic            busy, done, bout;
  logic [BITS-1:0] diff;
`ifdef SUB_OVERFLOW_EN
  logic            ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  chunk_subtractor #(.BITS(BITS), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SUB_OVERFLOW_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: an operation accepted while idle completes N edges later
  // with the full-width result of plain 65-bit arithmetic.
  logic            m_busy = 1'b0, m_done = 1'b0, m_bout = 1'b0, m_ovf = 1'b0, m_bin = 1'b0;
  logic [BITS-1:0] m_diff = '0, m_a = '0, m_b = '0;
  int              m_cnt = 0;

  task automatic chk(input string name, input logic [BITS-1:0] act, input logic [BITS-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: inputs change just after posedge, so at negedge they are
  // exactly what the next edge samples.
  always @(negedge clk) begin
    logic [BITS:0]   r;
    logic signed [BITS+1:0] s;
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_diff = '0; m_bout = 1'b0; m_ovf = 1'b0; m_cnt = 0;
    end
    chk("model_busy", BITS'(busy), BITS'(m_busy));
    chk("model_done", BITS'(done), BITS'(m_done));
    chk("model_diff", diff, m_diff);
    chk("model_bout", BITS'(bout), BITS'(m_bout));
`ifdef SUB_OVERFLOW_EN
    chk("model_ovf", BITS'(ovf), BITS'(m_ovf));
`endif
    if (rst_n) begin
      m_done = 1'b0;
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          r = {1'b0, m_a} - {1'b0, m_b} - (BITS+1)'(m_bin);
          s = $signed({{2{m_a[BITS-1]}}, m_a}) - $signed({{2{m_b[BITS-1]}}, m_b})
            - $signed((BITS+2)'(m_bin));
          m_diff = r[BITS-1:0];
          m_bout = r[BITS];
          m_ovf  = (s > $signed({3'b000, {(BITS-1){1'b1}}})) ||
                   (s < -$signed({3'b001, {(BITS-1){1'b0}}}));
          m_done = 1'b1;
          m_busy = 1'b0;
        end
      end else if (start) begin
        m_a = a; m_b = b; m_bin = bin;
        m_busy = 1'b1;
        m_cnt  = N;
      end
    end
  end

  // Waits (bounded) for the done cycle; returns negedges counted.
  task automatic wait_done(output int lat, output bit got);
    lat = 0; got = 0;
    for (int i = 0; i < 4 * N; i++) begin
      @(negedge clk);
      lat++;
      if (done) begin got = 1; break; end
    end
  endtask

  task automatic do_op(input string name, input logic [BITS-1:0] ta, input logic [BITS-1:0] tb_v,
                       input logic tbin, input logic [BITS-1:0] ediff, input logic ebout);
    int lat; bit got;
    @(posedge clk); #1;
    a = ta; b = tb_v; bin = tbin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, got);
    chk({name, "_seen"}, BITS'(got), BITS'(1));
    chk({name, "_lat"}, BITS'(lat), BITS'(N + 1));
    chk({name, "_diff"}, diff, ediff);
    chk({name, "_bout"}, BITS'(bout), BITS'(ebout));
  endtask

  initial begin
    int lat, busy_cycles, seen;
    bit got;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", BITS'(busy), '0);
    chk("rst_done", BITS'(done), '0);
    chk("rst_diff", diff, '0);
    chk("rst_bout", BITS'(bout), '0);
    rst_n = 1'b1;

    // Basic op; also count busy cycles.
    @(posedge clk); #1;
    a = 64'h10; b = 64'h1; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_cycles = 0; got = 0; lat = 0;
    for (int i = 0; i < 4 * N; i++) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cycles++;
      if (done) begin got = 1; break; end
    end
    chk("basic_busy_cycles", BITS'(busy_cycles), BITS'(N));
    chk("basic_lat", BITS'(lat), BITS'(N + 1));
    chk("basic_diff", diff, 64'hF);
    chk("basic_bout", BITS'(bout), '0);

    do_op("ripple", 64'h0, 64'h1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    do_op("bin1", 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    do_op("bin0", 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h0, 1'b0);
    do_op("top_chunk", 64'h0100_0000_0000_0000, 64'h0000_0000_0000_00FF, 1'b0, 64'h00FF_FFFF_FFFF_FF01, 1'b0);

    // Handshake: start held high, operands changed mid-op, back-to-back accept.
    @(posedge clk); #1;
    a = 64'h1000; b = 64'h0234; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 64'h50; b = 64'h20; bin = 1'b1;
    wait_done(lat, got);
    chk("hs_first_lat", BITS'(lat), BITS'(N + 1));
    chk("hs_first_diff", diff, 64'h0DCC);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, got);
    chk("hs_second_seen", BITS'(got), BITS'(1));
    chk("hs_second_gap", BITS'(lat), BITS'(N + 1));
    chk("hs_second_diff", diff, 64'h2F);

    // Reset mid-operation.
    @(posedge clk); #1;
    a = 64'h77; b = 64'h11; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", BITS'(busy), '0);
    chk("abort_done", BITS'(done), '0);
    chk("abort_diff", diff, '0);
    chk("abort_bout", BITS'(bout), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 2 * N; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort_no_done", BITS'(seen), '0);
    do_op("after_abort", 64'h5, 64'h3, 1'b0, 64'h2, 1'b0);

`ifdef SUB_OVERFLOW_EN
    do_op("ovf_pos", 64'h8000_0000_0000_0000, 64'h1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
    chk("ovf_pos_flag", BITS'(ovf), BITS'(1));
    do_op("ovf_neg", 64'h3, 64'h5, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    chk("ovf_neg_flag", BITS'(ovf), '0);
`endif

    // Random traffic, including start pulses while busy; the model checks every cycle.
    seen = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0: begin a = {$urandom, $urandom}; b = a; end
        1: begin a = 64'(CHUNK'($urandom)); b = {$urandom, $urandom}; end
        default: begin a = {$urandom, $urandom}; b = {$urandom, $urandom}; end
      endcase
      bin = 1'($urandom);
      if (done) seen++;
    end
    start = 1'b0;
    n_checks++;
    if (seen < 100) begin
      n_fail++;
      $display("FAIL rand_done_count: got %0d expected at least 100", seen);
    end
    repeat (2 * N) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
